// File: rtl/demo_pkg.sv
// demo_pkg: shared constants and types for the delta reader slice
package demo_pkg;
    localparam int WIDTH_DEF = 8;
    localparam logic [1:0] ALIGN_MASK = 2'b11;
    localparam int PREV_RST = 0;
    typedef enum logic {EMPTY, NONEMPTY} occ_t;
endpackage

// File: rtl/demo_delta_reader_if.sv
// demo_delta_reader_if: accumulator input, delta stream and status bundle
interface demo_delta_reader_if import demo_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] acc_in;
    logic [WIDTH-1:0] delta_out;
    logic             delta_valid;
    logic             delta_ready;
    logic             align_err;
    logic             overflow;
    logic [CNT_W-1:0] delta_cnt;
    modport master (output acc_in, delta_ready, input delta_out, delta_valid, align_err, overflow, delta_cnt);
    modport slave (input acc_in, delta_ready, output delta_out, delta_valid, align_err, overflow, delta_cnt);
endinterface

// File: rtl/demo_sync_fifo.sv
// demo_sync_fifo: small FIFO with registered head, accepts a push on full when a pop happens too
module demo_sync_fifo import demo_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_valid,
    output logic             o_push_ok
);
    localparam int PW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd;
    logic [PW-1:0]    r_wr;
    logic [PW:0]      r_cnt;
    occ_t             r_state;
    logic [WIDTH-1:0] r_head;
    logic             w_full;
    logic             w_pop;
    logic [PW-1:0]    w_rd_n;
    logic [PW:0]      w_cnt_n;
    assign w_full    = r_cnt == (PW+1)'(DEPTH);
    assign w_pop     = (r_state == NONEMPTY) && i_ready;
    assign o_push_ok = i_push && (!w_full || w_pop);
    assign w_rd_n    = w_pop ? r_rd + PW'(1) : r_rd;
    assign w_cnt_n   = r_cnt + (PW+1)'(o_push_ok) - (PW+1)'(w_pop);
    assign o_dout    = r_head;
    assign o_valid   = r_state == NONEMPTY;
    // Pointer/occupancy update; the head is preloaded so it is the new entry when the queue would otherwise be empty
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_cnt   <= '0;
            r_state <= EMPTY;
            r_head  <= '0;
        end else begin
            if (o_push_ok) begin
                r_mem[r_wr] <= i_din;
                r_wr        <= r_wr + PW'(1);
            end
            r_rd    <= w_rd_n;
            r_cnt   <= w_cnt_n;
            r_state <= (w_cnt_n != '0) ? NONEMPTY : EMPTY;
            r_head  <= (o_push_ok && r_wr == w_rd_n) ? i_din : r_mem[w_rd_n];
        end
    end
`ifdef FORMAL
    a_cnt_max: assert property (@(posedge clk) r_cnt <= (PW+1)'(DEPTH));
    a_valid_cnt: assert property (@(posedge clk) o_valid |-> r_cnt != '0);
`endif
endmodule

// File: rtl/demo_delta_reader.sv
// demo_delta_reader: recovers accumulator increments from its running sum and queues them
module demo_delta_reader import demo_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input logic           clk,
    input logic           reset,
    demo_delta_reader_if.slave bus
);
    logic [WIDTH-1:0] r_prev;
    logic             r_align_err;
    logic             r_overflow;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] w_d;
    logic             w_chg;
    logic             w_push_ok;
    assign w_chg = bus.acc_in != r_prev;
    assign w_d   = bus.acc_in - r_prev;
    demo_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_chg),
        .i_din     (w_d),
        .i_ready   (bus.delta_ready),
        .o_dout    (bus.delta_out),
        .o_valid   (bus.delta_valid),
        .o_push_ok (w_push_ok)
    );
    assign bus.align_err = r_align_err;
    assign bus.overflow  = r_overflow;
    assign bus.delta_cnt = r_cnt;
    // Track the last sum seen, raise sticky flags and count accepted deltas
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev      <= WIDTH'(PREV_RST);
            r_align_err <= 1'b0;
            r_overflow  <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_prev <= bus.acc_in;
            if (w_chg && (w_d[1:0] & ALIGN_MASK) != 2'b00) r_align_err <= 1'b1;
            if (w_chg && !w_push_ok) r_overflow <= 1'b1;
            if (w_push_ok) r_cnt <= r_cnt + CNT_W'(1);
        end
    end
`ifdef FORMAL
    logic [WIDTH-1:0] r_f_sum;
    // Sum of every accepted delta, popped or still queued
    always_ff @(posedge clk) begin
        if (reset) r_f_sum <= '0;
        else if (w_push_ok) r_f_sum <= r_f_sum + w_d;
    end
    a_sum: assert property (@(posedge clk) disable iff (reset) !r_overflow |-> r_f_sum == r_prev);
    a_stall: assert property (@(posedge clk) disable iff (reset) bus.delta_valid && !bus.delta_ready |=> $stable(bus.delta_out));
`endif
endmodule

// File: tb/tb_demo_delta_reader.sv
// tb_demo_delta_reader: directed checks of delta recovery, queueing, flags and reset
module tb_demo_delta_reader;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;
    demo_delta_reader_if bus ();
    demo_delta_reader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    initial begin
        n_chk = 0;
        n_fail = 0;
        reset = 1'b1;
        bus.acc_in = 8'h55;
        bus.delta_ready = 1'b0;
        tick();
        chk("rst_valid", 32'(bus.delta_valid), 0);
        chk("rst_out", 32'(bus.delta_out), 0);
        chk("rst_align", 32'(bus.align_err), 0);
        chk("rst_ovf", 32'(bus.overflow), 0);
        chk("rst_cnt", 32'(bus.delta_cnt), 0);
        reset = 1'b0;
        bus.acc_in = 8'h00;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_valid", 32'(bus.delta_valid), 0);
        end
        chk("idle_cnt", 32'(bus.delta_cnt), 0);
        chk("idle_flags", 32'({bus.align_err, bus.overflow}), 0);
        bus.delta_ready = 1'b1;
        bus.acc_in = 8'h04;
        tick();
        chk("seq_v0", 32'(bus.delta_valid), 1);
        chk("seq_d0", 32'(bus.delta_out), 32'h04);
        bus.acc_in = 8'h0C;
        tick();
        chk("seq_d1", 32'(bus.delta_out), 32'h08);
        bus.acc_in = 8'h18;
        tick();
        chk("seq_d2", 32'(bus.delta_out), 32'h0C);
        tick();
        chk("seq_drain", 32'(bus.delta_valid), 0);
        chk("seq_cnt", 32'(bus.delta_cnt), 3);
        bus.acc_in = 8'hF8;
        tick();
        chk("wrap_pre", 32'(bus.delta_out), 32'hE0);
        bus.acc_in = 8'h08;
        tick();
        chk("wrap_d", 32'(bus.delta_out), 32'h10);
        chk("wrap_align", 32'(bus.align_err), 0);
        tick();
        chk("wrap_drain", 32'(bus.delta_valid), 0);
        chk("wrap_cnt", 32'(bus.delta_cnt), 5);
        bus.delta_ready = 1'b0;
        bus.acc_in = 8'h0C;
        tick();
        bus.acc_in = 8'h14;
        tick();
        bus.acc_in = 8'h20;
        tick();
        bus.acc_in = 8'h30;
        tick();
        chk("full_ovf0", 32'(bus.overflow), 0);
        chk("full_head", 32'(bus.delta_out), 32'h04);
        bus.acc_in = 8'h44;
        tick();
        chk("full_ovf1", 32'(bus.overflow), 1);
        chk("full_cnt", 32'(bus.delta_cnt), 9);
        chk("full_stall", 32'(bus.delta_out), 32'h04);
        bus.delta_ready = 1'b1;
        bus.acc_in = 8'h5C;
        tick();
        chk("pp_head", 32'(bus.delta_out), 32'h08);
        chk("pp_ovf", 32'(bus.overflow), 1);
        chk("pp_cnt", 32'(bus.delta_cnt), 10);
        bus.delta_ready = 1'b0;
        tick();
        chk("pp_stall", 32'(bus.delta_out), 32'h08);
        bus.delta_ready = 1'b1;
        tick();
        chk("pp_d1", 32'(bus.delta_out), 32'h0C);
        tick();
        chk("pp_d2", 32'(bus.delta_out), 32'h10);
        tick();
        chk("pp_d3", 32'(bus.delta_out), 32'h18);
        chk("pp_v3", 32'(bus.delta_valid), 1);
        tick();
        chk("pp_drain", 32'(bus.delta_valid), 0);
        reset = 1'b1;
        bus.acc_in = 8'h00;
        bus.delta_ready = 1'b0;
        tick();
        reset = 1'b0;
        chk("r2_ovf", 32'(bus.overflow), 0);
        bus.acc_in = 8'h03;
        tick();
        chk("al_err", 32'(bus.align_err), 1);
        chk("al_d", 32'(bus.delta_out), 32'h03);
        bus.acc_in = 8'h07;
        tick();
        bus.acc_in = 8'h0B;
        tick();
        chk("q3_cnt", 32'(bus.delta_cnt), 3);
        reset = 1'b1;
        tick();
        chk("mid_valid", 32'(bus.delta_valid), 0);
        chk("mid_flags", 32'({bus.align_err, bus.overflow}), 0);
        chk("mid_cnt", 32'(bus.delta_cnt), 0);
        chk("mid_out", 32'(bus.delta_out), 0);
        reset = 1'b0;
        bus.acc_in = 8'h04;
        tick();
        chk("post_valid", 32'(bus.delta_valid), 1);
        chk("post_d", 32'(bus.delta_out), 32'h04);
        chk("post_cnt", 32'(bus.delta_cnt), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/demo_delta_reader.md
Name: demo_delta_reader

Overview:
- Reader at the output end of the demo accumulator.
- Watches the running sum on the accumulator's dout bus and recovers each increment the accumulator added, as delta = new sum - previous sum, modulo 256.
- Buffers recovered deltas in a small FIFO and delivers them downstream over a valid/ready handshake.
- Flags protocol violations with sticky bits: a delta that is not a multiple of 4, and FIFO overflow. Intended both as a functional consumer and as a formal-verification harness companion.

Parameters:
- WIDTH, 8, data width of acc_in and delta_out.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of the accepted-delta counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- acc_in  input  WIDTH  running sum from the accumulator's dout.
- delta_out  output  WIDTH  FIFO head data.
- delta_valid  output  1  FIFO non-empty.
- delta_ready  input  1  downstream accepts the head when high together with delta_valid.
- align_err  output  1  sticky: a recovered delta had bits [1:0] != 0.
- overflow  output  1  sticky: a delta was dropped because the FIFO was full.
- delta_cnt  output  CNT_W  number of deltas pushed into the FIFO; wraps modulo 2^CNT_W.

Behaviour:
- Reset: one clock, synchronous, active-high. While reset is high at a rising edge, the following happen:
  - prev <= 0, matching the accumulator's own reset value.
  - FIFO is emptied, so delta_valid = 0.
  - delta_out = 0.
  - align_err = 0, overflow = 0, delta_cnt = 0.
  - acc_in is ignored in a reset cycle.
- Change detection:
  - Each non-reset cycle, chg = (acc_in != prev) and d = acc_in - prev, truncated to WIDTH (wrap-around is legal, e.g. prev=0xFC, acc_in=0x04 gives d=0x08).
  - prev <= acc_in every non-reset cycle.
- Zero increments: the accumulator adding 0 leaves acc_in unchanged. This is indistinguishable from idle, so no entry is produced; this is defined behaviour, not an error.
- Push rules:
  - Push occurs when chg = 1.
  - Latency: a change on acc_in in cycle N appears at the FIFO head at the earliest in cycle N+1. Output is registered, with no combinational path from acc_in to the outputs.
  - If d[1:0] != 0, align_err <= 1. The delta is still pushed if there is space.
- FIFO full:
  - On chg with FIFO full and no pop in the same cycle, the delta is dropped, overflow <= 1, and delta_cnt does not increment.
  - If a pop occurs in the same cycle (delta_valid & delta_ready while full), the push is accepted.
- Pop rules:
  - Pop occurs on delta_valid & delta_ready.
  - delta_out and delta_valid are stable while delta_valid = 1 and delta_ready = 0.
  - delta_ready while empty has no effect.
- Simultaneous push and pop when non-empty: occupancy is unchanged and ordering is preserved (FIFO order).
- Push and pop when empty: the new entry becomes visible next cycle; there is no bypass.
- Counter: delta_cnt increments by 1 on every accepted push and wraps from 2^CNT_W-1 to 0.
- Sticky flags: align_err and overflow clear only on reset.
- Reset mid-operation: all queued deltas are lost and prev returns to 0. The first non-zero acc_in after reset is treated as a delta from 0.
- State: a two-state occupancy view (EMPTY / NONEMPTY) derived from count. Pointers are log2(DEPTH) bits and count is log2(DEPTH)+1 bits, giving an explicit full condition of count == DEPTH.

Decomposition:
- Package demo_pkg: WIDTH default, ALIGN_MASK = 2'b11, reset value of prev (0).
- Sub-module demo_sync_fifo (WIDTH, DEPTH): push/pop/full/empty with a registered head and same-cycle push-on-full-with-pop. The top level holds change detection, error flags and the counter.
- Formal properties, enabled in the formal build:
  - delta_valid implies count > 0.
  - count <= DEPTH.
  - No change of delta_out while stalled.
  - Sum of popped deltas + queued deltas == acc_in (mod 2^WIDTH) when overflow == 0.

Test Plan:
- Reset then acc_in held at 0 for 10 cycles -> delta_valid = 0 throughout, delta_cnt = 0, no flags.
- acc_in 0 -> 0x04 -> 0x0C -> 0x18 on consecutive cycles, delta_ready = 1 -> delta_out sequence 0x04, 0x08, 0x0C, each one cycle after its change; delta_cnt = 3.
- Wrap: prev 0xF8, acc_in 0x08 -> delta_out 0x10, align_err stays 0.
- delta_ready = 0, five distinct changes with DEPTH = 4 -> four entries held, overflow = 1, delta_cnt = 4. Then release delta_ready -> first four deltas emitted in order.
- Full FIFO, change and pop in the same cycle -> push accepted, overflow unchanged, count stays 4.
- acc_in 0x00 -> 0x03 -> align_err = 1 and delta 0x03 queued. Reset mid-queue with three entries -> delta_valid = 0 next cycle, flags cleared, acc_in = 0x04 afterwards yields delta 0x04.
